// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB request master.
package apb_master_pkg;

  localparam int unsigned APB_ADDR_W  = 32;
  localparam int unsigned APB_DATA_W  = 32;
  localparam int unsigned APB_TIMEOUT = 16;
  localparam int unsigned APB_WAIT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS wait states and flags when the completer has stalled too long.
module apb_wait_timer
  import apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [APB_WAIT_W-1:0] r_count;

  // Saturating wait counter, cleared at the start of every transfer.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (enable && (r_count != '1)) begin
      r_count <= r_count + APB_WAIT_W'(1);
    end
  end

  assign expired = (r_count == APB_WAIT_W'(TIMEOUT - 1));

endmodule

// File: rtl/apb_request_master.sv
// Turns single valid/ready requests into APB transfers, one outstanding at a time.
module apb_request_master
  import apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W,
  parameter int unsigned DATA_W  = APB_DATA_W,
  parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_error,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  apb_state_e        r_state, w_state;
  logic              r_req_ready, w_req_ready;
  logic              r_psel, w_psel;
  logic              r_penable, w_penable;
  logic              r_pwrite, w_pwrite;
  logic [ADDR_W-1:0] r_paddr, w_paddr;
  logic [DATA_W-1:0] r_pwdata, w_pwdata;
  logic              r_rsp_valid, w_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata;
  logic              r_rsp_error, w_rsp_error;
  logic              w_timer_clear;
  logic              w_timer_enable;
  logic              w_expired;

  assign w_timer_enable = (r_state == ST_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (PCLK),
    .rst    (PRESET),
    .clear  (w_timer_clear),
    .enable (w_timer_enable),
    .expired(w_expired)
  );

  // Next state plus next value of every registered output.
  // Outputs are decoded from the next state so they can all come straight from flops.
  always_comb begin
    w_state       = r_state;
    w_pwrite      = r_pwrite;
    w_paddr       = r_paddr;
    w_pwdata      = r_pwdata;
    w_rsp_rdata   = r_rsp_rdata;
    w_rsp_error   = r_rsp_error;
    w_timer_clear = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state       = ST_SETUP;
          w_pwrite      = req_write;
          w_paddr       = req_addr;
          w_pwdata      = req_wdata;
          w_timer_clear = 1'b1;
        end
      end
      ST_SETUP: begin
        w_state = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          w_state     = ST_RESP;
          w_rsp_rdata = r_pwrite ? '0 : PRDATA;
          w_rsp_error = PSLVERR;
        end else if (w_expired) begin
          w_state     = ST_RESP;
          w_rsp_rdata = '0;
          w_rsp_error = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state = ST_IDLE;
        end
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    w_req_ready = (w_state == ST_IDLE);
    w_psel      = (w_state == ST_SETUP) || (w_state == ST_ACCESS);
    w_penable   = (w_state == ST_ACCESS);
    w_rsp_valid = (w_state == ST_RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_req_ready <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_req_ready <= w_req_ready;
      r_psel      <= w_psel;
      r_penable   <= w_penable;
      r_pwrite    <= w_pwrite;
      r_paddr     <= w_paddr;
      r_pwdata    <= w_pwdata;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_rdata <= w_rsp_rdata;
      r_rsp_error <= w_rsp_error;
    end
  end

  assign req_ready = r_req_ready;
  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;

endmodule
